// File: rtl/dm_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory unit.
//   - size codes for the access-width field driven by the EX/MEM register
//   - FSM state encoding (also visible on the unit's fsm_state debug output)
//   - is_aligned(): natural-alignment rule per access size
package dm_access_unit_pkg;

    localparam logic [1:0] DM_WORD = 2'b00;
    localparam logic [1:0] DM_HALF = 2'b01;
    localparam logic [1:0] DM_BYTE = 2'b10;
    // 2'b11 is not named: it is handled exactly like DM_WORD everywhere.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dm_state_t;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            DM_HALF: return ~off[0];
            DM_BYTE: return 1'b1;
            default: return (off == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering between the 32-bit RAM word and the
// right-justified pipeline data.
//   size      : access size code (DM_WORD/DM_HALF/DM_BYTE, 11 = word)
//   sign_ext  : loads only, 1 = sign-extend sub-word data
//   byte_off  : addr[1:0] of the access (assumed already aligned)
//   wdata     : right-justified store data
//   word      : current RAM word at the access index
//   merged    : RAM word with the store lanes replaced
//   load_data : extracted and extended load value
module dm_lane_align
    import dm_access_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b    = word[{byte_off, 3'b000} +: 8];
        lane_h    = word[{byte_off[1], 4'b0000} +: 16];
        merged    = word;
        load_data = word;
        case (size)
            DM_BYTE: begin
                merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
                load_data = {{24{sign_ext & lane_b[7]}}, lane_b};
            end
            DM_HALF: begin
                // Half lanes are selected by addr[1] only; addr[0] is 0 once aligned.
                merged[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
                load_data = {{16{sign_ext & lane_h[15]}}, lane_h};
            end
            default: begin
                merged    = wdata;
                load_data = word;
            end
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// MEM-stage data-memory unit: wait-stated RAM with byte/half/word lanes.
//   clk, rst        : clock, asynchronous active-low reset
//   mem_read/write  : request (store wins when both are set)
//   size, sign_ext  : access width and load extension
//   addr, wdata     : byte address and right-justified store data
//   rdata           : registered load result, valid in DONE
//   stall           : freeze upstream stages while an access is in flight
//   misalign        : request in IDLE whose address is not size-aligned
//   bad_addr/valid  : sticky capture of the first misaligned address
//   dbg_sel/data    : combinational RAM word read
//   fsm_state       : current FSM state for observation
// Valid/ready style: the pipeline holds a request while stall=1; the access
// is accepted in IDLE and the result is consumed on the DONE cycle edge.
module dm_access_unit
    import dm_access_unit_pkg::*;
#(
    parameter int AW   = 10,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [1:0]    size,
    input  logic          sign_ext,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          stall,
    output logic          misalign,
    output logic [31:0]   bad_addr,
    output logic          bad_valid,
    input  logic [AW-1:0] dbg_sel,
    output logic [31:0]   dbg_data,
    output logic [1:0]    fsm_state
);

    dm_state_t     state;
    logic [3:0]    cnt;
    // Request fields are captured on acceptance so a pipeline flush that
    // drops the request mid-access cannot corrupt the committed access.
    logic [AW-1:0] acc_idx;
    logic [1:0]    acc_off;
    logic [1:0]    acc_size;
    logic          acc_sext;
    logic          acc_write;
    logic [31:0]   acc_wdata;

    logic [31:0]   mem [0:(2**AW)-1];

    logic          req;
    logic          aligned;
    logic          commit;
    logic [31:0]   cur_word;
    logic [31:0]   merged;
    logic [31:0]   load_data;

    assign req      = mem_read | mem_write;
    assign aligned  = is_aligned(size, addr[1:0]);
    assign commit   = (state == ST_BUSY) && (cnt == 4'd0);
    assign cur_word = mem[acc_idx];

    dm_lane_align u_lane (
        .size      (acc_size),
        .sign_ext  (acc_sext),
        .byte_off  (acc_off),
        .wdata     (acc_wdata),
        .word      (cur_word),
        .merged    (merged),
        .load_data (load_data)
    );

    // Stall is asserted combinationally in the acceptance cycle so the
    // pipeline freezes from the first cycle the request is visible.
    assign stall     = rst && ((state == ST_BUSY) ||
                               ((state == ST_IDLE) && req && aligned));
    assign misalign  = (state == ST_IDLE) && req && !aligned;
    assign dbg_data  = mem[dbg_sel];
    assign fsm_state = state;

    // RAM has no reset; while rst is low the FSM sits in IDLE so commit is 0.
    always_ff @(posedge clk) begin
        if (commit && acc_write) begin
            mem[acc_idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            rdata     <= 32'd0;
            bad_addr  <= 32'd0;
            bad_valid <= 1'b0;
            acc_idx   <= '0;
            acc_off   <= 2'b00;
            acc_size  <= DM_WORD;
            acc_sext  <= 1'b0;
            acc_write <= 1'b0;
            acc_wdata <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req && aligned) begin
                        state     <= ST_BUSY;
                        cnt       <= 4'(WAIT);
                        acc_idx   <= addr[AW+1:2];
                        acc_off   <= addr[1:0];
                        acc_size  <= size;
                        acc_sext  <= sign_ext;
                        acc_write <= mem_write;
                        acc_wdata <= wdata;
                    end else if (req && !bad_valid) begin
                        bad_addr  <= addr;
                        bad_valid <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!acc_write) begin
                            rdata <= load_data;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
